// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl
// Turns N debounced button levels into PRESS / RELEASE / LONG / REPEAT events.
// Each button has a small FSM that posts events into a one-deep pending slot.
// A round-robin arbiter moves one pending event per cycle into a shared
// first-word-fall-through FIFO, which the consumer drains over valid/ready.
//
// Ports:
//   i_clk        clock
//   i_rstn       asynchronous active-low reset
//   i_btn        debounced button levels, 1 = pressed
//   i_rep_en     enables REPEAT generation while a button is held
//   o_evt_valid  FIFO head is valid
//   i_evt_ready  consumer accepts the head this cycle
//   o_evt_btn    button index of the head event
//   o_evt_type   head event type: 0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT
//   i_ovf_clr    clears o_overflow (a simultaneous new overflow wins)
//   o_overflow   sticky: a pending event was overwritten before it was queued
module btn_event_ctrl #(
  parameter int unsigned N_BTN         = 4,
  parameter int unsigned LONG_CYCLES   = 1000,
  parameter int unsigned REPEAT_CYCLES = 250,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic [N_BTN-1:0]           i_btn,
  input  logic                       i_rep_en,
  output logic                       o_evt_valid,
  input  logic                       i_evt_ready,
  output logic [$clog2(N_BTN)-1:0]   o_evt_btn,
  output logic [1:0]                 o_evt_type,
  input  logic                       i_ovf_clr,
  output logic                       o_overflow
);

  localparam int unsigned BW      = $clog2(N_BTN);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    EvPress   = 2'd0,
    EvRelease = 2'd1,
    EvLong    = 2'd2,
    EvRepeat  = 2'd3
  } evt_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPressed = 2'd1,
    StHeld    = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Per-button FSMs
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] btn_prev_q;
  state_e           state_q [N_BTN];
  state_e           state_d [N_BTN];
  logic [CW-1:0]    cnt_q   [N_BTN];
  logic [CW-1:0]    cnt_d   [N_BTN];
  logic [N_BTN-1:0] post;
  evt_e             post_type [N_BTN];

  always_comb begin
    for (int i = 0; i < int'(N_BTN); i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      post[i]      = 1'b0;
      post_type[i] = EvPress;
      case (state_q[i])
        StIdle: begin
          // Edge against btn_prev (cleared by reset), so a button held
          // through reset still reports a PRESS.
          if (i_btn[i] && !btn_prev_q[i]) begin
            state_d[i]   = StPressed;
            cnt_d[i]     = '0;
            post[i]      = 1'b1;
            post_type[i] = EvPress;
          end
        end
        StPressed: begin
          if (!i_btn[i]) begin
            state_d[i]   = StIdle;
            cnt_d[i]     = '0;
            post[i]      = 1'b1;
            post_type[i] = EvRelease;
          end else if (cnt_q[i] == LONG_LAST) begin
            state_d[i]   = StHeld;
            cnt_d[i]     = '0;
            post[i]      = 1'b1;
            post_type[i] = EvLong;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        StHeld: begin
          if (!i_btn[i]) begin
            state_d[i]   = StIdle;
            cnt_d[i]     = '0;
            post[i]      = 1'b1;
            post_type[i] = EvRelease;
          end else if (!i_rep_en) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == REP_LAST) begin
            cnt_d[i]     = '0;
            post[i]      = 1'b1;
            post_type[i] = EvRepeat;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          state_d[i] = StIdle;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      btn_prev_q <= '0;
      for (int i = 0; i < int'(N_BTN); i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
    end else begin
      btn_prev_q <= i_btn;
      for (int i = 0; i < int'(N_BTN); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending slots and round-robin arbiter
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] pend_vld_q, pend_vld_d;
  evt_e             pend_type_q [N_BTN];
  evt_e             pend_type_d [N_BTN];
  logic [BW-1:0]    last_q;
  logic [N_BTN-1:0] gnt;
  logic             gnt_any;
  logic [BW-1:0]    gnt_idx;
  evt_e             gnt_type;
  logic             ovf_set;

  logic             fifo_full;
  logic             push;
  logic             pop;
  logic             can_push;

  assign pop      = o_evt_valid & i_evt_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign can_push = ~fifo_full | pop;

  always_comb begin
    int unsigned idx;
    gnt      = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    gnt_type = EvPress;
    idx      = 0;
    for (int unsigned off = 0; off < N_BTN; off++) begin
      idx = (32'(last_q) + 32'd1 + off) % N_BTN;
      if (can_push && !gnt_any && pend_vld_q[idx]) begin
        gnt_any     = 1'b1;
        gnt[idx]    = 1'b1;
        gnt_idx     = BW'(idx);
        gnt_type    = pend_type_q[idx];
      end
    end
  end

  always_comb begin
    ovf_set = 1'b0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      pend_vld_d[i]  = pend_vld_q[i];
      pend_type_d[i] = pend_type_q[i];
      if (post[i]) begin
        // Newest event wins; only a slot that is not draining this cycle loses data.
        pend_vld_d[i]  = 1'b1;
        pend_type_d[i] = post_type[i];
        if (pend_vld_q[i] && !gnt[i]) begin
          ovf_set = 1'b1;
        end
      end else if (gnt[i]) begin
        pend_vld_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pend_vld_q <= '0;
      last_q     <= BW'(N_BTN - 1);  // first search after reset starts at index 0
      o_overflow <= 1'b0;
      for (int i = 0; i < int'(N_BTN); i++) begin
        pend_type_q[i] <= EvPress;
      end
    end else begin
      pend_vld_q <= pend_vld_d;
      for (int i = 0; i < int'(N_BTN); i++) begin
        pend_type_q[i] <= pend_type_d[i];
      end
      if (gnt_any) begin
        last_q <= gnt_idx;
      end
      if (ovf_set) begin
        o_overflow <= 1'b1;
      end else if (i_ovf_clr) begin
        o_overflow <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO (first-word-fall-through, extra pointer bit tells full from empty)
  // ---------------------------------------------------------------------------
  logic [BW-1:0] mem_btn_q  [FIFO_DEPTH];
  logic [1:0]    mem_type_q [FIFO_DEPTH];
  logic [AW:0]   wptr_q, rptr_q;

  assign push      = gnt_any;
  assign fifo_full = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_btn_q[i]  <= '0;
        mem_type_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_btn_q[wptr_q[AW-1:0]]  <= gnt_idx;
        mem_type_q[wptr_q[AW-1:0]] <= gnt_type;
        wptr_q                     <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  assign o_evt_valid = (wptr_q != rptr_q);
  assign o_evt_btn   = mem_btn_q[rptr_q[AW-1:0]];
  assign o_evt_type  = mem_type_q[rptr_q[AW-1:0]];

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed testbench for btn_event_ctrl with default parameters
// (4 buttons, LONG 1000, REPEAT 250, FIFO depth 4). A monitor logs every
// accepted event with the edge count at which it was visible.
module tb_btn_event_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] btn;
  logic       rep_en;
  logic       valid;
  logic       ready;
  logic [1:0] ebtn;
  logic [1:0] etype;
  logic       ovf_clr;
  logic       ovf;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t0, t1;

  typedef struct {
    int btn;
    int typ;
    int cyc;
  } evt_t;
  evt_t evq[$];

  btn_event_ctrl dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_btn       (btn),
    .i_rep_en    (rep_en),
    .o_evt_valid (valid),
    .i_evt_ready (ready),
    .o_evt_btn   (ebtn),
    .o_evt_type  (etype),
    .i_ovf_clr   (ovf_clr),
    .o_overflow  (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rstn && valid && ready) begin
      evq.push_back('{btn: int'(ebtn), typ: int'(etype), cyc: cyc});
    end
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // exp_cyc < 0 skips the timing comparison.
  task automatic check_evt(input string tag, input int idx, input int exp_btn,
                           input int exp_typ, input int exp_cyc);
    if (idx < evq.size()) begin
      check_val({tag, ".btn"}, evq[idx].btn, exp_btn);
      check_val({tag, ".type"}, evq[idx].typ, exp_typ);
      if (exp_cyc >= 0) check_val({tag, ".cyc"}, evq[idx].cyc, exp_cyc);
    end else begin
      check_val({tag, ".present"}, 0, 1);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves four events in the FIFO: (0,P) (0,R) (1,P) (1,R).
  task automatic fill_four();
    btn[0] = 1'b1; wait_cyc(2);
    btn[0] = 1'b0; wait_cyc(2);
    btn[1] = 1'b1; wait_cyc(2);
    btn[1] = 1'b0; wait_cyc(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; btn = '0; rep_en = 1'b0; ready = 1'b0; ovf_clr = 1'b0;
    wait_cyc(2);
    check_val("rst.valid", int'(valid), 0);
    check_val("rst.btn", int'(ebtn), 0);
    check_val("rst.type", int'(etype), 0);
    check_val("rst.ovf", int'(ovf), 0);
    rstn = 1'b1;
    wait_cyc(2);

    // Simultaneous presses right after reset: search starts at 0.
    ready = 1'b1;
    evq.delete();
    t0 = cyc; btn = 4'hF; wait_cyc(8);
    check_val("simul1.count", evq.size(), 4);
    for (int i = 0; i < 4; i++) check_evt("simul1", i, i, 0, t0 + 2 + i);
    btn = '0; wait_cyc(8);
    btn[0] = 1'b1; wait_cyc(3);
    btn[0] = 1'b0; wait_cyc(3);
    // Button 0 was last granted, so the next round starts at 1.
    evq.delete();
    t0 = cyc; btn = 4'hF; wait_cyc(8);
    check_val("simul2.count", evq.size(), 4);
    for (int i = 0; i < 4; i++) check_evt("simul2", i, (i + 1) % 4, 0, t0 + 2 + i);
    btn = '0; wait_cyc(8);

    // Short press on button 1.
    evq.delete();
    t0 = cyc; btn[1] = 1'b1; wait_cyc(20);
    t1 = cyc; btn[1] = 1'b0; wait_cyc(5);
    check_val("short.count", evq.size(), 2);
    check_evt("short.press", 0, 1, 0, t0 + 2);
    check_evt("short.release", 1, 1, 1, t1 + 2);
    check_val("short.ovf", int'(ovf), 0);

    // Long hold with repeats on button 2.
    rep_en = 1'b1;
    evq.delete();
    t0 = cyc; btn[2] = 1'b1; wait_cyc(1600);
    t1 = cyc; btn[2] = 1'b0; wait_cyc(5);
    check_val("rep.count", evq.size(), 5);
    check_evt("rep.press", 0, 2, 0, t0 + 2);
    check_evt("rep.long", 1, 2, 2, t0 + 1002);
    check_evt("rep.rep1", 2, 2, 3, t0 + 1252);
    check_evt("rep.rep2", 3, 2, 3, t0 + 1502);
    check_evt("rep.release", 4, 2, 1, t1 + 2);

    // Same hold without repeats.
    rep_en = 1'b0;
    evq.delete();
    t0 = cyc; btn[2] = 1'b1; wait_cyc(1600);
    t1 = cyc; btn[2] = 1'b0; wait_cyc(5);
    check_val("norep.count", evq.size(), 3);
    check_evt("norep.press", 0, 2, 0, t0 + 2);
    check_evt("norep.long", 1, 2, 2, t0 + 1002);
    check_evt("norep.release", 2, 2, 1, t1 + 2);

    // Overflow: full FIFO, button 3 posts four times into its slot.
    ready = 1'b0;
    evq.delete();
    fill_four();
    check_val("ovf.valid", int'(valid), 1);
    check_val("ovf.head_btn", int'(ebtn), 0);
    check_val("ovf.head_type", int'(etype), 0);
    btn[3] = 1'b1; wait_cyc(2);
    check_val("ovf.first_post", int'(ovf), 0);
    btn[3] = 1'b0; wait_cyc(2);
    check_val("ovf.set", int'(ovf), 1);
    btn[3] = 1'b1; wait_cyc(2);
    btn[3] = 1'b0; wait_cyc(2);
    check_val("ovf.head_kept", int'(ebtn), 0);
    ready = 1'b1; wait_cyc(8);
    check_val("ovf.count", evq.size(), 5);
    check_evt("ovf.e0", 0, 0, 0, -1);
    check_evt("ovf.e1", 1, 0, 1, -1);
    check_evt("ovf.e2", 2, 1, 0, -1);
    check_evt("ovf.e3", 3, 1, 1, -1);
    check_evt("ovf.e4", 4, 3, 1, -1);
    check_val("ovf.sticky", int'(ovf), 1);
    ovf_clr = 1'b1; wait_cyc(1);
    ovf_clr = 1'b0;
    check_val("ovf.clr", int'(ovf), 0);

    // Full FIFO with a pending slot: push and pop together for one cycle.
    ready = 1'b0;
    evq.delete();
    fill_four();
    btn[2] = 1'b1; wait_cyc(2);
    ready = 1'b1; wait_cyc(1);
    ready = 1'b0;
    check_val("fullpp.ovf", int'(ovf), 0);
    check_val("fullpp.head_btn", int'(ebtn), 0);
    check_val("fullpp.head_type", int'(etype), 1);
    ready = 1'b1; wait_cyc(8);
    check_val("fullpp.count", evq.size(), 5);
    check_evt("fullpp.e4", 4, 2, 0, -1);
    check_val("fullpp.ovf_end", int'(ovf), 0);
    btn[2] = 1'b0; wait_cyc(5);

    // Reset with three queued events and button 1 held.
    ready = 1'b0;
    evq.delete();
    btn[1] = 1'b1; wait_cyc(1003);
    btn[0] = 1'b1; wait_cyc(3);
    check_val("rstmid.valid_before", int'(valid), 1);
    rstn = 1'b0; btn[0] = 1'b0; ready = 1'b1;
    #1;
    check_val("rstmid.valid", int'(valid), 0);
    check_val("rstmid.ovf", int'(ovf), 0);
    check_val("rstmid.btn", int'(ebtn), 0);
    wait_cyc(2);
    evq.delete();
    t0 = cyc; rstn = 1'b1; wait_cyc(5);
    check_val("rstmid.count", evq.size(), 1);
    check_evt("rstmid.press", 0, 1, 0, t0 + 2);
    btn = '0; wait_cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_event_ctrl.md
# btn_event_ctrl

Button event scheduler placed after the per-button debouncers. It turns N debounced button levels into discrete PRESS, RELEASE, LONG and REPEAT events. A round-robin arbiter shares a single event FIFO between the buttons, and the CPU drains the FIFO over a valid/ready handshake.

## Interface
- `N_BTN`, 4: number of buttons; must be ≥2.
- `LONG_CYCLES`, 1000: cycles from a PRESS event to the LONG event; must be ≥2.
- `REPEAT_CYCLES`, 250: cycles between consecutive REPEAT events after LONG; must be ≥2.
- `FIFO_DEPTH`, 4: event FIFO entries; must be a power of 2 and ≥2.
- `i_clk`, in, 1: clock.
- `i_rstn`, in, 1: asynchronous active-low reset.
- `i_btn`, in, N_BTN: debounced levels; 1 = pressed.
- `i_rep_en`, in, 1: enables REPEAT generation.
- `o_evt_valid`, out, 1: FIFO head valid.
- `i_evt_ready`, in, 1: consumer accepts the head.
- `o_evt_btn`, out, $clog2(N_BTN): button index of the head event.
- `o_evt_type`, out, 2: event type at the head; 0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT.
- `i_ovf_clr`, in, 1: clears `o_overflow`.
- `o_overflow`, out, 1: sticky flag; an event was lost.

## Operation
- Reset (async, `i_rstn`=0):
  - `o_evt_valid`, `o_evt_btn`, `o_evt_type` and `o_overflow` are 0.
  - FIFO is empty; all pending slots are clear.
  - The btn_prev register is 0, all per-button FSMs are IDLE and all counters are 0.
  - Consequence: a button held through reset produces PRESS after reset is released.
- Per-button FSM:
  - IDLE → PRESSED when `i_btn`=1 and btn_prev=0; posts PRESS and clears the counter.
  - PRESSED: counter increments each cycle. When the counter reaches LONG_CYCLES-1, posts LONG, goes to HELD and clears the counter.
  - HELD: when `i_rep_en`=1 and the counter reaches REPEAT_CYCLES-1, posts REPEAT and clears the counter. When `i_rep_en`=0, the counter holds at 0.
  - PRESSED or HELD → IDLE when `i_btn`=0; posts RELEASE. RELEASE takes precedence over LONG or REPEAT in the same cycle.
- Pending slots: one per button, each holding valid plus type.
  - A new post into an occupied slot that is not granted in the same cycle overwrites the slot (newest wins) and sets `o_overflow`.
  - A post into a slot that is granted in the same cycle does not overflow; the new event stays pending.
- Arbiter:
  - Each cycle where FIFO has space (not full, or full with a pop this cycle), grants one pending slot, round-robin.
  - Search starts at last-granted index +1 (mod N_BTN); after reset it starts at index 0.
  - The granted slot's event is written to the FIFO and the slot is cleared.
  - When no grant is possible, slots hold.
- FIFO:
  - First-word-fall-through; read and write pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Pop occurs when `o_evt_valid` & `i_evt_ready`.
  - Push and pop in the same cycle: allowed at any fill level, including full.
- Overflow: `i_ovf_clr` clears `o_overflow`. A set event in the same cycle as `i_ovf_clr` wins, so the flag stays 1.

## Timing
- Latency with no contention and an empty FIFO:
  - `i_btn` change sampled at edge k → pending set at edge k.
  - FIFO write at edge k+1 → `o_evt_valid`=1 after edge k+1 (2 edges).
- LONG is posted exactly LONG_CYCLES edges after PRESS was posted while the button stays held. REPEATs follow every REPEAT_CYCLES edges.
- Throughput: one FIFO write and one read per cycle maximum.
- `o_evt_btn` and `o_evt_type` are stable while `o_evt_valid`=1 and `i_evt_ready`=0.
- All outputs are registered or come directly from FIFO storage; there is no combinational path from `i_btn` to any output.
- Reset mid-operation: everything returns to reset values immediately, and queued events are discarded.

## Test plan
- Press btn 1 for 20 cycles with LONG_CYCLES=1000, then release; `i_evt_ready`=1 → exactly (1,PRESS) 2 edges after the rise and (1,RELEASE) 2 edges after the fall; `o_overflow`=0.
- Hold btn 2 for 1600 cycles with `i_rep_en`=1, LONG_CYCLES=1000, REPEAT_CYCLES=250 → PRESS, then LONG at +1000, REPEAT at +1250 and +1500, then RELEASE; with `i_rep_en`=0, no REPEATs.
- Press btns 0–3 in the same cycle with an empty FIFO and ready=1 → PRESS events exit in order 0,1,2,3 on consecutive cycles. A second simultaneous press set, with btn 0 last granted, exits in order 1,2,3,0.
- `i_evt_ready`=0 with FIFO_DEPTH=4: generate 4 events, then press and release btn 3 twice → FIFO holds the first 4 and `o_overflow`=1. Btn 3's slot holds RELEASE, which drains 5th once ready=1. `i_ovf_clr` then clears the flag.
- FIFO full with ready=1 and a pending slot → push and pop in the same cycle; count stays 4 and no overflow.
- Assert reset while the FIFO holds 3 events and btn 1 is HELD → `o_evt_valid`=0 and `o_overflow`=0 immediately. After release with btn 1 still held, PRESS for btn 1 arrives at edge 2.
